// File: rtl/cache_pkg.sv
// Shared sizing and state encoding for the cache-to-memory line controller.
package cache_pkg;

    localparam int ADDR_L    = 32;
    localparam int CACHE_LEN = 8;
    localparam int MEM_W     = 32;
    localparam int LINE_W    = 8 * CACHE_LEN;
    localparam int BEATS     = LINE_W / MEM_W;
    localparam int OFS_L     = $clog2(CACHE_LEN);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_BEAT = 3'd1,
        RD_CMD  = 3'd2,
        RD_WAIT = 3'd3,
        DONE    = 3'd4
    } state_t;

    function automatic int beat_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/cache_mem_ctrl_if.sv
// Cache line request/response signals plus the word-wide memory command bus.
interface cache_mem_ctrl_if #(
    parameter int ADDR_L    = cache_pkg::ADDR_L,
    parameter int CACHE_LEN = cache_pkg::CACHE_LEN,
    parameter int MEM_W     = cache_pkg::MEM_W
);
    logic                   c_req;
    logic                   c_we;
    logic [ADDR_L-1:0]      c_addr;
    logic [8*CACHE_LEN-1:0] c_wdata;
    logic                   c_busy;
    logic                   c_ack;
    logic [8*CACHE_LEN-1:0] c_rdata;
    logic                   m_valid;
    logic                   m_we;
    logic [ADDR_L-1:0]      m_addr;
    logic [MEM_W-1:0]       m_wdata;
    logic                   m_ready;
    logic                   m_rvalid;
    logic [MEM_W-1:0]       m_rdata;

    // Controller view: serves the cache, drives the memory bus.
    modport slave (
        input  c_req, c_we, c_addr, c_wdata, m_ready, m_rvalid, m_rdata,
        output c_busy, c_ack, c_rdata, m_valid, m_we, m_addr, m_wdata
    );

    // Environment view: the cache plus the memory.
    modport master (
        output c_req, c_we, c_addr, c_wdata, m_ready, m_rvalid, m_rdata,
        input  c_busy, c_ack, c_rdata, m_valid, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/cache_mem_ctrl.sv
// Splits cache line refills/writebacks into word beats on the memory bus.
// Latency: write BEATS+1, read 2*BEATS+1 cycles; m_ready stalls hold the beat.
module cache_mem_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_L    = cache_pkg::ADDR_L,
    parameter int CACHE_LEN = cache_pkg::CACHE_LEN,
    parameter int MEM_W     = cache_pkg::MEM_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cache_mem_ctrl_if.slave      bus
);

    localparam int LW = 8 * CACHE_LEN;
    localparam int NB = LW / MEM_W;
    localparam int BW = beat_w(NB);
    localparam logic [BW-1:0]     LAST   = BW'(NB - 1);
    localparam logic [ADDR_L-1:0] WORD_B = ADDR_L'(MEM_W / 8);
    localparam logic [ADDR_L-1:0] OFS_M  = ADDR_L'(CACHE_LEN - 1);

    state_t            state, state_nxt;
    logic [BW-1:0]     beat_q, beat_nxt;
    logic [ADDR_L-1:0] base_q;
    logic [LW-1:0]     wdata_q;
    logic [LW-1:0]     line_q, line_nxt;
    logic [LW-1:0]     rdata_q;

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat_q;
        case (state)
            IDLE: begin
                if (bus.c_req) begin
                    state_nxt = bus.c_we ? WR_BEAT : RD_CMD;
                    beat_nxt  = '0;
                end
            end
            WR_BEAT: begin
                if (bus.m_ready) begin
                    if (beat_q == LAST) state_nxt = DONE;
                    else                beat_nxt  = beat_q + BW'(1);
                end
            end
            RD_CMD: begin
                if (bus.m_ready) state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                if (bus.m_rvalid) begin
                    if (beat_q == LAST) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = RD_CMD;
                        beat_nxt  = beat_q + BW'(1);
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        line_nxt = line_q;
        line_nxt[beat_q*MEM_W +: MEM_W] = bus.m_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            beat_q  <= '0;
            base_q  <= '0;
            wdata_q <= '0;
            line_q  <= '0;
            rdata_q <= '0;
        end else begin
            state  <= state_nxt;
            beat_q <= beat_nxt;
            if (state == IDLE && bus.c_req) begin
                base_q  <= bus.c_addr & ~OFS_M;
                wdata_q <= bus.c_wdata;
            end
            // Published line only changes when the final beat lands, so c_rdata
            // stays the previous line throughout a refill.
            if (state == RD_WAIT && bus.m_rvalid) begin
                line_q <= line_nxt;
                if (beat_q == LAST) rdata_q <= line_nxt;
            end
        end
    end

    assign bus.c_busy  = (state != IDLE);
    assign bus.c_ack   = (state == DONE);
    assign bus.c_rdata = rdata_q;
    assign bus.m_valid = (state == WR_BEAT) || (state == RD_CMD);
    assign bus.m_we    = (state == WR_BEAT);
    assign bus.m_addr  = base_q + ADDR_L'(beat_q) * WORD_B;
    assign bus.m_wdata = wdata_q[beat_q*MEM_W +: MEM_W];

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Directed bench for cache_mem_ctrl with a simple responding memory model.
module tb_cache_mem_ctrl;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    cache_mem_ctrl_if bus ();

    cache_mem_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model state and logs
    int          stall_cnt;
    bit          rsp_en;
    bit          stray;
    bit          pend;
    logic [31:0] pend_addr;
    int          ack_cnt;
    logic [31:0] cmd_addr[$];
    logic [31:0] cmd_dat[$];
    logic        cmd_we[$];
    logic [31:0] vlog_addr[$];
    logic [31:0] vlog_dat[$];

    function automatic logic [31:0] memfn(input logic [31:0] a);
        case (a)
            32'h0000_1230: return 32'hAAAA_0001;
            32'h0000_1234: return 32'hBBBB_0002;
            default:       return a ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (bus.m_valid && stall_cnt > 0) begin
                bus.m_ready = 1'b0;
                stall_cnt   = stall_cnt - 1;
            end else begin
                bus.m_ready = 1'b1;
            end
            bus.m_rvalid = 1'b0;
            if (pend && rsp_en) begin
                bus.m_rvalid = 1'b1;
                bus.m_rdata  = memfn(pend_addr);
                pend         = 1'b0;
            end else if (stray && bus.m_valid && !bus.m_we && !pend) begin
                bus.m_rvalid = 1'b1;
                bus.m_rdata  = 32'hDEAD_BEEF;
                stray        = 1'b0;
            end
            if (bus.m_valid) begin
                vlog_addr.push_back(bus.m_addr);
                vlog_dat.push_back(bus.m_wdata);
            end
            if (bus.m_valid && bus.m_ready) begin
                cmd_addr.push_back(bus.m_addr);
                cmd_dat.push_back(bus.m_wdata);
                cmd_we.push_back(bus.m_we);
                if (!bus.m_we) begin
                    pend      = 1'b1;
                    pend_addr = bus.m_addr;
                end
            end
            if (bus.c_ack) ack_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic clear_logs();
        cmd_addr.delete();
        cmd_dat.delete();
        cmd_we.delete();
        vlog_addr.delete();
        vlog_dat.delete();
        ack_cnt = 0;
    endtask

    // Issues one request from IDLE, returns edges-to-ack, leaves DUT back in IDLE.
    task automatic run_req(input logic we, input logic [31:0] addr,
                           input logic [63:0] wd, output int lat);
        bus.c_req   = 1'b1;
        bus.c_we    = we;
        bus.c_addr  = addr;
        bus.c_wdata = wd;
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (i == 1) bus.c_req = 1'b0;
            if (bus.c_ack) begin
                lat = i;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total_cnt++;
        if (bus.c_busy !== 1'b0 || bus.c_ack !== 1'b0 || bus.m_valid !== 1'b0 || bus.m_we !== 1'b0)
            $display("FAIL reset_ctrl: busy/ack/valid/we=%b%b%b%b required 0000",
                     bus.c_busy, bus.c_ack, bus.m_valid, bus.m_we);
        else pass_cnt++;
        total_cnt++;
        if (bus.m_addr !== 32'h0 || bus.m_wdata !== 32'h0 || bus.c_rdata !== 64'h0)
            $display("FAIL reset_data: m_addr=%h m_wdata=%h c_rdata=%h required 0",
                     bus.m_addr, bus.m_wdata, bus.c_rdata);
        else pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read_ideal();
        int lat;
        clear_logs();
        run_req(1'b0, 32'h0000_1234, 64'h0, lat);
        total_cnt++;
        if (lat !== 5) $display("FAIL read_latency: got %0d required 5", lat);
        else pass_cnt++;
        total_cnt++;
        if (cmd_addr.size() != 2 || cmd_addr[0] !== 32'h1230 || cmd_addr[1] !== 32'h1234 ||
            cmd_we[0] !== 1'b0 || cmd_we[1] !== 1'b0)
            $display("FAIL read_addr_seq: count=%0d first=%h required 2 cmds 1230,1234 reads",
                     cmd_addr.size(), (cmd_addr.size() > 0) ? cmd_addr[0] : 32'hx);
        else pass_cnt++;
        total_cnt++;
        if (bus.c_rdata !== 64'hBBBB_0002_AAAA_0001)
            $display("FAIL read_data: got %h required bbbb0002aaaa0001", bus.c_rdata);
        else pass_cnt++;
        total_cnt++;
        if (ack_cnt !== 1) $display("FAIL read_ack_count: got %0d required 1", ack_cnt);
        else pass_cnt++;
    endtask

    task automatic test_write_stall();
        int lat;
        bit stable;
        clear_logs();
        stall_cnt = 3;
        run_req(1'b1, 32'h0000_0040, 64'h1122_3344_5566_7788, lat);
        total_cnt++;
        if (lat !== 6) $display("FAIL write_latency: got %0d required 6", lat);
        else pass_cnt++;
        total_cnt++;
        if (vlog_addr.size() != 5) $display("FAIL write_valid_cycles: got %0d required 5", vlog_addr.size());
        else pass_cnt++;
        stable = 1'b1;
        for (int i = 0; i < 4; i++)
            if (i >= vlog_addr.size() || vlog_addr[i] !== 32'h40 || vlog_dat[i] !== 32'h5566_7788)
                stable = 1'b0;
        total_cnt++;
        if (!stable) $display("FAIL write_beat0_hold: beat 0 not 40/55667788 for 4 cycles, first=%h/%h",
                              (vlog_addr.size() > 0) ? vlog_addr[0] : 32'hx,
                              (vlog_dat.size() > 0) ? vlog_dat[0] : 32'hx);
        else pass_cnt++;
        total_cnt++;
        if (cmd_addr.size() != 2 || cmd_addr[1] !== 32'h44 || cmd_dat[1] !== 32'h1122_3344 ||
            cmd_we[0] !== 1'b1 || cmd_we[1] !== 1'b1)
            $display("FAIL write_beat1: count=%0d last=%h/%h required 2 writes, 44/11223344",
                     cmd_addr.size(), (cmd_addr.size() > 1) ? cmd_addr[1] : 32'hx,
                     (cmd_dat.size() > 1) ? cmd_dat[1] : 32'hx);
        else pass_cnt++;
        total_cnt++;
        if (ack_cnt !== 1 || bus.c_rdata !== 64'hBBBB_0002_AAAA_0001)
            $display("FAIL write_ack_rdata: acks=%0d rdata=%h required 1, bbbb0002aaaa0001",
                     ack_cnt, bus.c_rdata);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int acks, lows, ack2_at;
        clear_logs();
        acks = 0; lows = 0; ack2_at = -1;
        bus.c_req   = 1'b1;
        bus.c_we    = 1'b1;
        bus.c_addr  = 32'h0000_0100;
        bus.c_wdata = 64'hA1A2_A3A4_A5A6_A7A8;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == 1) bus.c_wdata = 64'hB1B2_B3B4_B5B6_B7B8;
            if (bus.c_ack) acks++;
            if (!bus.c_busy && acks == 1) lows++;
            if (acks == 2) begin
                ack2_at  = i;
                bus.c_req = 1'b0;
                break;
            end
        end
        repeat (3) begin @(posedge clk); #1; end
        total_cnt++;
        if (ack2_at !== 7) $display("FAIL b2b_second_ack_cycle: got %0d required 7", ack2_at);
        else pass_cnt++;
        total_cnt++;
        if (lows !== 1) $display("FAIL b2b_busy_low: got %0d cycles required 1", lows);
        else pass_cnt++;
        total_cnt++;
        if (ack_cnt !== 2 || bus.c_busy !== 1'b0)
            $display("FAIL b2b_ack_count: acks=%0d busy=%b required 2, 0", ack_cnt, bus.c_busy);
        else pass_cnt++;
        total_cnt++;
        if (cmd_addr.size() != 4 || cmd_addr[0] !== 32'h100 || cmd_addr[1] !== 32'h104 ||
            cmd_addr[2] !== 32'h100 || cmd_addr[3] !== 32'h104 ||
            cmd_dat[0] !== 32'hA5A6_A7A8 || cmd_dat[1] !== 32'hA1A2_A3A4 ||
            cmd_dat[2] !== 32'hB5B6_B7B8 || cmd_dat[3] !== 32'hB1B2_B3B4)
            $display("FAIL b2b_beats: count=%0d third=%h required 4 beats, third b5b6b7b8",
                     cmd_addr.size(), (cmd_dat.size() > 2) ? cmd_dat[2] : 32'hx);
        else pass_cnt++;
    endtask

    task automatic test_ignored_req();
        int lat;
        clear_logs();
        stray = 1'b1;
        bus.c_req  = 1'b1;
        bus.c_we   = 1'b0;
        bus.c_addr = 32'h0000_0300;
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (i == 1) bus.c_req = 1'b0;
            if (i == 2) begin
                bus.c_req  = 1'b1;
                bus.c_we   = 1'b1;
                bus.c_addr = 32'h0000_0500;
            end
            if (i == 3) bus.c_req = 1'b0;
            if (bus.c_ack) begin
                lat = i;
                break;
            end
        end
        repeat (4) begin @(posedge clk); #1; end
        total_cnt++;
        if (lat !== 5) $display("FAIL ign_latency: got %0d required 5", lat);
        else pass_cnt++;
        total_cnt++;
        if (cmd_addr.size() != 2 || cmd_addr[0] !== 32'h300 || cmd_addr[1] !== 32'h304 ||
            cmd_we[0] !== 1'b0 || cmd_we[1] !== 1'b0 || ack_cnt !== 1 || bus.c_busy !== 1'b0)
            $display("FAIL ign_no_extra_txn: cmds=%0d acks=%0d busy=%b required 2 reads, 1 ack, idle",
                     cmd_addr.size(), ack_cnt, bus.c_busy);
        else pass_cnt++;
        total_cnt++;
        if (bus.c_rdata !== 64'h5A5A_595E_5A5A_595A)
            $display("FAIL ign_data: got %h required 5a5a595e5a5a595a", bus.c_rdata);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_read();
        int lat;
        clear_logs();
        rsp_en     = 1'b0;
        bus.c_req  = 1'b1;
        bus.c_we   = 1'b0;
        bus.c_addr = 32'h0000_0600;
        @(posedge clk); #1;
        bus.c_req = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (bus.m_valid !== 1'b0 || bus.c_busy !== 1'b1)
            $display("FAIL rst_pre_wait: valid=%b busy=%b required 0, 1", bus.m_valid, bus.c_busy);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (bus.m_valid !== 1'b0 || bus.c_busy !== 1'b0 || bus.c_ack !== 1'b0 || bus.c_rdata !== 64'h0)
            $display("FAIL rst_immediate: valid=%b busy=%b ack=%b rdata=%h required 0,0,0,0",
                     bus.m_valid, bus.c_busy, bus.c_ack, bus.c_rdata);
        else pass_cnt++;
        @(posedge clk); #1;
        rst_n  = 1'b1;
        rsp_en = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        total_cnt++;
        if (ack_cnt !== 0 || bus.c_busy !== 1'b0)
            $display("FAIL rst_stale_ignored: acks=%0d busy=%b required 0, 0", ack_cnt, bus.c_busy);
        else pass_cnt++;
        run_req(1'b0, 32'h0000_0200, 64'h0, lat);
        total_cnt++;
        if (lat !== 5 || bus.c_rdata !== 64'h5A5A_585E_5A5A_585A)
            $display("FAIL rst_fresh_read: lat=%0d rdata=%h required 5, 5a5a585e5a5a585a",
                     lat, bus.c_rdata);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        int lat;
        clear_logs();
        run_req(1'b0, 32'hFFFF_FFF9, 64'h0, lat);
        total_cnt++;
        if (cmd_addr.size() != 2 || cmd_addr[0] !== 32'hFFFF_FFF8 || cmd_addr[1] !== 32'hFFFF_FFFC)
            $display("FAIL wrap_addr: count=%0d first=%h required fffffff8,fffffffc",
                     cmd_addr.size(), (cmd_addr.size() > 0) ? cmd_addr[0] : 32'hx);
        else pass_cnt++;
        total_cnt++;
        if (lat !== 5 || bus.c_rdata !== 64'hA5A5_A5A6_A5A5_A5A2)
            $display("FAIL wrap_data: lat=%0d rdata=%h required 5, a5a5a5a6a5a5a5a2", lat, bus.c_rdata);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt     = 0;
        total_cnt    = 0;
        stall_cnt    = 0;
        rsp_en       = 1'b1;
        stray        = 1'b0;
        pend         = 1'b0;
        pend_addr    = '0;
        ack_cnt      = 0;
        bus.c_req    = 1'b0;
        bus.c_we     = 1'b0;
        bus.c_addr   = '0;
        bus.c_wdata  = '0;
        bus.m_ready  = 1'b1;
        bus.m_rvalid = 1'b0;
        bus.m_rdata  = '0;
        test_reset();
        test_read_ideal();
        test_write_stall();
        test_back_to_back();
        test_ignored_req();
        test_reset_mid_read();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
